id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the 16-bit, 5-bit-opcode datapath. It sits directly downstream of the operand-source decoder and the register file read ports.
- Each cycle it captures the decoded instruction and resolves ALU operand B using the decoder's alu_src2 flag: register operand for R-type, immediate otherwise. It presents registered operands to the ALU.
- It supports pipeline stall (hold), flush (bubble injection) and a saturating bubble counter for performance visibility.

Parameters:
- WIDTH, 16, datapath width of operands and immediate
- CNT_WIDTH, 16, width of bubble counter
- NOP_OPCODE, 5'b00001, opcode driven on ex_opcode when a bubble occupies the stage

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold current EX contents, ignore ID inputs
- flush  input  1  replace EX contents with bubble on next edge
- id_valid  input  1  ID stage holds a real instruction
- id_opcode  input  5  decoded opcode
- id_alu_src2  input  1  1 = operand B from id_rt_data, 0 = from id_imm
- id_rs_data  input  WIDTH  register file read port 1
- id_rt_data  input  WIDTH  register file read port 2
- id_imm  input  WIDTH  sign/zero-extended immediate from decode
- id_wr_reg  input  3  destination register index
- id_reg_write  input  1  instruction writes register file
- ex_valid  output  1  EX stage holds a real instruction
- ex_opcode  output  5  registered opcode
- ex_op_a  output  WIDTH  registered operand A (= captured id_rs_data)
- ex_op_b  output  WIDTH  registered operand B (mux result)
- ex_rt_data  output  WIDTH  registered id_rt_data (store data path)
- ex_wr_reg  output  3  registered destination index
- ex_reg_write  output  1  registered write enable, forced 0 for bubbles
- bubble_cnt  output  CNT_WIDTH  count of bubble cycles since reset, saturating

Behaviour:
- One clock; reset is synchronous and active-high (clk, rst). There is no asynchronous path.
- Reset values:
  - ex_valid=0, ex_opcode=NOP_OPCODE, ex_reg_write=0.
  - ex_op_a, ex_op_b, ex_rt_data and ex_wr_reg are all 0.
  - bubble_cnt=0.
- Latency: 1 cycle. Inputs sampled at edge N appear on the ex_* outputs after edge N.
- Operand B is selected at capture: ex_op_b <= id_alu_src2 ? id_rt_data : id_imm. There is no combinational path from id_* to ex_*.
- Each edge applies exactly one of these actions, in priority order:
  1. rst: reset values as listed above.
  2. flush (regardless of stall): load a bubble, i.e. ex_valid=0, ex_opcode=NOP_OPCODE, ex_reg_write=0, data fields and ex_wr_reg=0.
  3. stall: all ex_* registers hold their values, and bubble_cnt holds.
  4. Otherwise (load): if id_valid=1, capture all id_* fields and set ex_valid=1. If id_valid=0, load a bubble, identical to the flush case.
- A bubble must never assert ex_reg_write, even if id_reg_write=1 in the same cycle.
- Bubble counter:
  - Increments by 1 on each edge where a bubble is loaded (flush, or load with id_valid=0).
  - Does not increment on stall edges or on reset.
  - Saturates at all-ones: it stays at 2^CNT_WIDTH-1 and does not wrap.
- Stall spanning many cycles: outputs are stable for the whole stall. On release, the next edge captures the current id_* values, not the values present when the stall started.
- Reset mid-stall or mid-flush: reset wins, and outputs and counter return to reset values.
- The block has no internal FSM beyond the valid/bubble state. The state is {BUBBLE, VALID}:
  - BUBBLE -> VALID on load with id_valid=1.
  - Any state -> BUBBLE on flush, rst, or load with id_valid=0.
  - Stall holds the state.

Test Plan:
- Reset: assert rst 2 cycles with all inputs at 1s -> ex_valid=0, ex_opcode=5'b00001, ex_reg_write=0, ex_op_a=ex_op_b=0, bubble_cnt=0.
- Operand mux, R-type: id_valid=1, id_opcode=5'b11011, id_alu_src2=1, rs=16'h1234, rt=16'h00FF, imm=16'hFFF0 -> next cycle ex_op_a=16'h1234, ex_op_b=16'h00FF, ex_valid=1. Then I-type with opcode 5'b01000, alu_src2=0, same data -> ex_op_b=16'hFFF0.
- Stall hold: load opcode 5'b11100, then stall=1 for 3 cycles while id_* changes every cycle -> ex_* is constant and bubble_cnt is unchanged. Release -> capture of the newest id_* values.
- Flush priority: stall=1 and flush=1 together, with id_reg_write=1 -> next cycle ex_valid=0, ex_reg_write=0, ex_opcode=5'b00001, bubble_cnt+1.
- Invalid input: id_valid=0 for 4 consecutive unstalled cycles -> ex_valid=0 throughout and bubble_cnt increases by 4.
- Saturation, with CNT_WIDTH=4 override: apply 20 bubble cycles -> bubble_cnt reaches 4'hF and stays there. Then assert rst mid-sequence -> bubble_cnt=0 on the next edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register.
// Captures the decoded instruction, resolves ALU operand B at capture time,
// supports stall (hold), flush (bubble injection) and keeps a saturating
// count of bubble cycles for performance visibility.
module id_ex_stage #(
  parameter int         WIDTH      = 16,
  parameter int         CNT_WIDTH  = 16,
  parameter logic [4:0] NOP_OPCODE = 5'b00001
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 id_valid,
  input  logic [4:0]           id_opcode,
  input  logic                 id_alu_src2,
  input  logic [WIDTH-1:0]     id_rs_data,
  input  logic [WIDTH-1:0]     id_rt_data,
  input  logic [WIDTH-1:0]     id_imm,
  input  logic [2:0]           id_wr_reg,
  input  logic                 id_reg_write,
  output logic                 ex_valid,
  output logic [4:0]           ex_opcode,
  output logic [WIDTH-1:0]     ex_op_a,
  output logic [WIDTH-1:0]     ex_op_b,
  output logic [WIDTH-1:0]     ex_rt_data,
  output logic [2:0]           ex_wr_reg,
  output logic                 ex_reg_write,
  output logic [CNT_WIDTH-1:0] bubble_cnt
);

  // The only control state is whether the stage holds a bubble or a real
  // instruction; everything else is payload.
  typedef enum logic {S_BUBBLE = 1'b0, S_VALID = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [4:0]           opcode_q, opcode_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d;
  logic [WIDTH-1:0]     op_b_q, op_b_d;
  logic [WIDTH-1:0]     rt_q, rt_d;
  logic [2:0]           wr_reg_q, wr_reg_d;
  logic                 reg_write_q, reg_write_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 bubble_ld;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  // Next-state: flush beats stall; an unstalled edge with no valid
  // instruction loads a bubble exactly like a flush does.
  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rt_d        = rt_q;
    wr_reg_d    = wr_reg_q;
    reg_write_d = reg_write_q;
    bubble_ld   = 1'b0;

    if (flush || (!stall && !id_valid)) begin
      bubble_ld   = 1'b1;
      state_d     = S_BUBBLE;
      opcode_d    = NOP_OPCODE;
      op_a_d      = '0;
      op_b_d      = '0;
      rt_d        = '0;
      wr_reg_d    = '0;
      // A bubble never writes the register file, whatever id_reg_write says.
      reg_write_d = 1'b0;
    end else if (!stall) begin
      state_d     = S_VALID;
      opcode_d    = id_opcode;
      op_a_d      = id_rs_data;
      // Operand B is resolved here so the ALU sees a single registered value.
      op_b_d      = id_alu_src2 ? id_rt_data : id_imm;
      rt_d        = id_rt_data;
      wr_reg_d    = id_wr_reg;
      reg_write_d = id_reg_write;
    end
  end

  // Bubble counter: count loaded bubbles, stick at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (bubble_ld && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State and payload registers with synchronous reset to the bubble values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_BUBBLE;
      opcode_q    <= NOP_OPCODE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rt_q        <= '0;
      wr_reg_q    <= '0;
      reg_write_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rt_q        <= rt_d;
      wr_reg_q    <= wr_reg_d;
      reg_write_q <= reg_write_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ex_valid     = (state_q == S_VALID);
  assign ex_opcode    = opcode_q;
  assign ex_op_a      = op_a_q;
  assign ex_op_b      = op_b_q;
  assign ex_rt_data   = rt_q;
  assign ex_wr_reg    = wr_reg_q;
  assign ex_reg_write = reg_write_q;
  assign bubble_cnt   = cnt_q;

endmodule
